// File: rtl/bsg_bypass_fifo_pkg.sv
// Shared types and constants for the two-entry bypass FIFO.
package bsg_bypass_fifo_pkg;

  localparam int unsigned els_lp = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } count_e;

endpackage

// File: rtl/bsg_bypass_fifo_2_mem.sv
// Two-entry register file: one synchronous write port, one asynchronous read port, no reset.
module bsg_bypass_fifo_2_mem
  import bsg_bypass_fifo_pkg::*;
#(
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               w_v_i,
  input  logic               w_addr_i,
  input  logic [width_p-1:0] w_data_i,
  input  logic               r_addr_i,
  output logic [width_p-1:0] r_data_o
);

  logic [width_p-1:0] mem_r [els_lp];

  always_ff @(posedge clk_i) begin
    if (w_v_i) mem_r[w_addr_i] <= w_data_i;
  end

  assign r_data_o = mem_r[r_addr_i];

endmodule

// File: rtl/bsg_bypass_fifo_2.sv
// Two-entry FIFO with zero-latency bypass when empty; ready_o depends on state only.
module bsg_bypass_fifo_2
  import bsg_bypass_fifo_pkg::*;
#(
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  count_e             count_r;
  logic               rd_ptr_r, wr_ptr_r;
  logic               enq, deq, bypass, we, rd;
  logic [width_p-1:0] head_data;

  assign ready_o = (count_r != FULL) & reset_n_i;
  assign v_o     = reset_n_i & ((count_r != EMPTY) | v_i);
  assign enq     = v_i & ready_o;
  // Gating with v_o keeps an illegal yumi_i from disturbing state.
  assign deq     = yumi_i & v_o;
  assign bypass  = (count_r == EMPTY) & enq & deq;
  assign we      = enq & ~bypass;
  assign rd      = deq & (count_r != EMPTY);
  assign data_o  = (count_r == EMPTY) ? data_i : head_data;

  bsg_bypass_fifo_2_mem #(.width_p(width_p)) mem (
    .clk_i    (clk_i),
    .w_v_i    (we),
    .w_addr_i (wr_ptr_r),
    .w_data_i (data_i),
    .r_addr_i (rd_ptr_r),
    .r_data_o (head_data)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_r  <= EMPTY;
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
    end else begin
      if (we) wr_ptr_r <= ~wr_ptr_r;
      if (rd) rd_ptr_r <= ~rd_ptr_r;
      case (count_r)
        EMPTY: if (we) count_r <= ONE;
        ONE: begin
          if (enq & ~deq)      count_r <= FULL;
          else if (~enq & deq) count_r <= EMPTY;
        end
        FULL:    if (deq) count_r <= ONE;
        default: count_r <= EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(yumi_i && !v_o)) else $error("bsg_bypass_fifo_2: yumi_i asserted while v_o=0");
    end
  end

endmodule

// File: tb/tb_bsg_bypass_fifo_2.sv
// Directed and random checks of bsg_bypass_fifo_2 against a queue-based reference model.
module tb_bsg_bypass_fifo_2;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        v_i = 1'b0;
  logic [15:0] data_i = '0;
  logic        yumi_i = 1'b0;
  logic        ready_o, v_o;
  logic [15:0] data_o;

  int checks = 0;
  int errors = 0;
  logic [15:0] q[$];

  bsg_bypass_fifo_2 #(.width_p(16)) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (v_i),
    .data_i    (data_i),
    .ready_o   (ready_o),
    .v_o       (v_o),
    .data_o    (data_o),
    .yumi_i    (yumi_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic       exp_ready, exp_v;
    logic [15:0] exp_data;
    exp_ready = reset_n_i && (q.size() < 2);
    exp_v     = reset_n_i && ((q.size() > 0) || v_i);
    exp_data  = (q.size() == 0) ? data_i : q[0];
    chk({tag, ".ready"}, 16'(ready_o), 16'(exp_ready));
    chk({tag, ".v"}, 16'(v_o), 16'(exp_v));
    if (exp_v) chk({tag, ".data"}, data_o, exp_data);
  endtask

  // Drive one cycle: apply inputs, check outputs mid-cycle, advance model and clock.
  task automatic step(input logic v, input logic [15:0] d, input logic y, input string tag);
    logic enq;
    v_i = v; data_i = d; yumi_i = y;
    #2;
    check_outputs(tag);
    if (reset_n_i) begin
      enq = v && (q.size() < 2);
      if (!(q.size() == 0 && enq && y)) begin
        if (y && q.size() > 0) void'(q.pop_front());
        if (enq) q.push_back(d);
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // Reset held with v_i high
    reset_n_i = 1'b0;
    step(1'b1, 16'h1234, 1'b0, "reset0");
    step(1'b1, 16'h1234, 1'b0, "reset1");
    // Release between edges; bypass in the first cycle
    reset_n_i = 1'b1;
    step(1'b1, 16'hA5A5, 1'b1, "bypass");
    step(1'b0, 16'h0000, 1'b0, "after_bypass");
    // Fill and stall
    step(1'b1, 16'h0001, 1'b0, "fill1");
    step(1'b1, 16'h0002, 1'b0, "fill2");
    step(1'b1, 16'h0003, 1'b0, "held_off");
    chk("full.ready", 16'(ready_o), 16'h0);
    // Drain
    step(1'b0, 16'h0000, 1'b1, "drain1");
    step(1'b0, 16'h0000, 1'b1, "drain2");
    step(1'b0, 16'h0000, 1'b0, "drained");
    // Streaming at ONE
    step(1'b1, 16'h0010, 1'b0, "preload");
    for (int unsigned i = 16'h11; i <= 16'h18; i++) step(1'b1, 16'(i), 1'b1, "stream");
    step(1'b0, 16'h0000, 1'b1, "stream_tail");
    step(1'b0, 16'h0000, 1'b0, "stream_empty");
    // Mid-operation reset pulse while FULL
    step(1'b1, 16'h00AA, 1'b0, "pre_rst1");
    step(1'b1, 16'h00BB, 1'b0, "pre_rst2");
    v_i = 1'b1; data_i = 16'h00CC; yumi_i = 1'b0;
    reset_n_i = 1'b0;
    #1;
    chk("midrst.v", 16'(v_o), 16'h0);
    chk("midrst.ready", 16'(ready_o), 16'h0);
    q.delete();
    reset_n_i = 1'b1;
    #1;
    step(1'b1, 16'h0077, 1'b0, "post_rst");
    step(1'b0, 16'h0000, 1'b1, "post_rst_drain");
    step(1'b0, 16'h0000, 1'b0, "post_rst_empty");
    // Random traffic; yumi only offered when a word is visible
    for (int unsigned n = 0; n < 400; n++) begin
      logic        rv, ry;
      logic [15:0] rd;
      rv = 1'($urandom_range(0, 1));
      rd = 16'($urandom);
      ry = ((q.size() > 0) || rv) ? 1'($urandom_range(0, 1)) : 1'b0;
      step(rv, rd, ry, "random");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
